port_request_scheduler: RTL and testbench
=========================================

PORT_REQUEST_SCHEDULER -- requirements
Module: port_request_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, per-port request FIFO depth; legal values are powers of 2, at least 2.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 portN_req_valid  input  1  request present on port N, N = 1..3.
REQ-005 portN_req_ready  output  1  port N FIFO can accept a request.
REQ-006 portN_addr / portN_datain / portN_wen / portN_req_tag_in  input  10/16/1/2  request fields.
REQ-007 issue_stall  input  1  downstream memory cannot take a bundle this cycle.
REQ-008 issueN_valid / issueN_addr / issueN_datain / issueN_wen / issueN_req_tag  output  1/10/16/1/2  registered issue bundle, one lane per port; feeds the steerer port inputs.
REQ-009 issueN_id  output  2  constant port id of lane N (2'd1, 2'd2, 2'd3).
REQ-010 conflict_count  output  16  conflict statistics; present only under REQ-030.

Function
REQ-011 Each port SHALL own a FIFO of FIFO_DEPTH entries storing {addr, datain, wen, tag}.
REQ-012 A request SHALL be accepted on an edge where portN_req_valid and portN_req_ready are both 1.
REQ-013 portN_req_ready SHALL be 1 exactly when FIFO N is not full; it is a registered-state function and does not depend on portN_req_valid.
REQ-014 A FIFO that is full and pops on the same edge SHALL NOT accept on that edge (ready is already 0); an empty FIFO SHALL NOT pop.
REQ-015 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counters are log2(FIFO_DEPTH)+1 bits wide.
REQ-016 Candidate set on each cycle: the heads of all non-empty FIFOs.
REQ-017 Conflict definition: two candidates conflict when their addresses are equal and at least one of them is a write.
REQ-018 Within each conflicting group, only the candidate nearest the round-robin pointer SHALL be granted; the order starts at the pointer port and runs 1->2->3->1. Every non-conflicting candidate SHALL be granted.
REQ-019 The round-robin pointer is a 3-state register (P1, P2, P3), reset to P1. On any edge where a conflict suppresses at least one candidate and issue_stall=0, it SHALL advance to the port after the highest-priority granted port. Otherwise it holds.
REQ-020 When issue_stall=0, each granted candidate SHALL pop from its FIFO, and its fields SHALL load into lane N with issueN_valid=1.
REQ-021 Lanes that are not granted SHALL load issueN_valid=0 and all-zero fields.
REQ-022 When issue_stall=1, no FIFO SHALL pop, the pointer SHALL hold, and all issueN_valid SHALL be 0 on the next cycle. Enqueue continues during a stall.
REQ-023 Latency: a request accepted at edge T into an empty FIFO, with no conflict and no stall, SHALL appear on issueN_* after edge T+1.
REQ-024 Requests from the same port SHALL issue in acceptance order; each accepted request SHALL issue exactly once.
REQ-025 Every issued bundle SHALL be conflict-free, i.e. no two valid lanes satisfy REQ-017.
REQ-026 Starvation bound: a candidate that is suppressed by conflict SHALL be granted within 2 non-stalled cycles.

Reset
REQ-027 While rst=1, the block SHALL immediately drive:
  - all FIFOs empty, all pointers 0;
  - portN_req_ready=1, issueN_valid=0, issue fields 0;
  - round-robin pointer P1; conflict_count=0.
REQ-028 Requests in flight at reset assertion SHALL be discarded; no issue occurs until the first edge after rst deasserts.
REQ-029 issueN_id SHALL be constant, independent of reset.

Configuration
REQ-030 Macro SCHED_STATS_EN, when defined, SHALL add conflict_count.
  - It increments by 1 on each edge where REQ-019 advances the pointer.
  - It saturates at 16'hFFFF.
  - Without the macro, the port and its counter SHALL be absent, and scheduling behaviour SHALL be identical.

Verification
REQ-031 Three ports each send a read to different addresses 0x010/0x020/0x030 in one cycle -> one cycle later all three issueN_valid=1 with matching fields and tags.
REQ-032 Ports 1 and 3 write address 0x055 in the same cycle, pointer P1 -> lane1 issues first, then lane3 issues on the next cycle; pointer moves to P2; conflict_count=1 with SCHED_STATS_EN.
REQ-033 Hold port2_req_valid high with issue_stall=1 -> accepts 4 requests, port2_req_ready=0 on the 5th cycle. Release the stall -> 4 issues in order, and ready returns 1 one cycle after the first pop.
REQ-034 Port 2 reads 0x100 while port 1 writes 0x100, pointer P2 -> the port 2 read issues first, the port 1 write issues next; a port 3 read to 0x200 issues in the first bundle.
REQ-035 Assert rst with two entries queued in each FIFO -> issueN_valid=0 and ready=1 immediately; after deassertion no stale request ever issues.

Source files
------------

// File: rtl/port_request_scheduler.sv
// Three-port request scheduler: per-port FIFOs feed a conflict-aware round-robin issue stage.
// Optional macro SCHED_STATS_EN adds the saturating conflict_count output.
module port_request_scheduler #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        port1_req_valid,
    output logic        port1_req_ready,
    input  logic [9:0]  port1_addr,
    input  logic [15:0] port1_datain,
    input  logic        port1_wen,
    input  logic [1:0]  port1_req_tag_in,
    input  logic        port2_req_valid,
    output logic        port2_req_ready,
    input  logic [9:0]  port2_addr,
    input  logic [15:0] port2_datain,
    input  logic        port2_wen,
    input  logic [1:0]  port2_req_tag_in,
    input  logic        port3_req_valid,
    output logic        port3_req_ready,
    input  logic [9:0]  port3_addr,
    input  logic [15:0] port3_datain,
    input  logic        port3_wen,
    input  logic [1:0]  port3_req_tag_in,
    input  logic        issue_stall,
    output logic        issue1_valid,
    output logic [9:0]  issue1_addr,
    output logic [15:0] issue1_datain,
    output logic        issue1_wen,
    output logic [1:0]  issue1_req_tag,
    output logic [1:0]  issue1_id,
    output logic        issue2_valid,
    output logic [9:0]  issue2_addr,
    output logic [15:0] issue2_datain,
    output logic        issue2_wen,
    output logic [1:0]  issue2_req_tag,
    output logic [1:0]  issue2_id,
    output logic        issue3_valid,
    output logic [9:0]  issue3_addr,
    output logic [15:0] issue3_datain,
    output logic        issue3_wen,
    output logic [1:0]  issue3_req_tag,
`ifdef SCHED_STATS_EN
    output logic [15:0] conflict_count,
`endif
    output logic [1:0]  issue3_id
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [9:0]  addr;
        logic [15:0] datain;
        logic        wen;
        logic [1:0]  tag;
    } req_t;

    typedef enum logic [1:0] {P1 = 2'd0, P2 = 2'd1, P3 = 2'd2} rr_t;

    function automatic rr_t rr_next(input rr_t p);
        case (p)
            P1:      return P2;
            P2:      return P3;
            default: return P1;
        endcase
    endfunction

    logic [2:0]    in_valid;
    logic [2:0]    in_ready;
    logic [2:0]    push;
    logic [2:0]    pop;
    logic [2:0]    cand;
    logic [2:0]    grant;
    logic          suppress;
    req_t          in_req   [3];
    req_t          head     [3];
    req_t          mem_q    [3][FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q [3];
    logic [AW-1:0] rd_ptr_q [3];
    logic [AW:0]   cnt_q    [3];
    logic [1:0]    rank     [3];
    rr_t           rr_q;
    rr_t           rr_d;
    rr_t           idx;
    rr_t           top;
    logic          found;
    logic [2:0]    iss_valid_q;
    req_t          iss_q    [3];

    assign in_valid  = {port3_req_valid, port2_req_valid, port1_req_valid};
    assign in_req[0] = {port1_addr, port1_datain, port1_wen, port1_req_tag_in};
    assign in_req[1] = {port2_addr, port2_datain, port2_wen, port2_req_tag_in};
    assign in_req[2] = {port3_addr, port3_datain, port3_wen, port3_req_tag_in};

    always_comb begin
        cand     = '0;
        in_ready = '0;
        for (int i = 0; i < 3; i++) begin
            head[i]     = mem_q[i][rd_ptr_q[i]];
            cand[i]     = (cnt_q[i] != '0);
            in_ready[i] = (cnt_q[i] != FULL_CNT);
        end
        push = in_valid & in_ready;
    end

    // A candidate loses only to a conflicting candidate closer to the round-robin pointer.
    always_comb begin
        rank = '{default: 2'd0};
        idx  = rr_q;
        for (int k = 0; k < 3; k++) begin
            rank[idx] = 2'(k);
            idx       = rr_next(idx);
        end

        grant = '0;
        for (int i = 0; i < 3; i++) begin
            grant[i] = cand[i];
            for (int j = 0; j < 3; j++) begin
                if (j != i && cand[j] && head[i].addr == head[j].addr &&
                    (head[i].wen || head[j].wen) && rank[j] < rank[i]) begin
                    grant[i] = 1'b0;
                end
            end
        end
        suppress = |(cand & ~grant);

        top   = rr_q;
        found = 1'b0;
        idx   = rr_q;
        for (int k = 0; k < 3; k++) begin
            if (!found && grant[idx]) begin
                top   = idx;
                found = 1'b1;
            end
            idx = rr_next(idx);
        end

        rr_d = rr_q;
        if (suppress && !issue_stall) begin
            rr_d = rr_next(top);
        end
        pop = issue_stall ? 3'b000 : grant;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= in_req[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
                iss_q[i]    <= '0;
            end
            iss_valid_q <= '0;
            rr_q        <= P1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (push[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + AW'(1);
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
                end
                case ({push[i], pop[i]})
                    2'b10:   cnt_q[i] <= cnt_q[i] + (AW+1)'(1);
                    2'b01:   cnt_q[i] <= cnt_q[i] - (AW+1)'(1);
                    default: cnt_q[i] <= cnt_q[i];
                endcase
                iss_q[i] <= pop[i] ? head[i] : '0;
            end
            iss_valid_q <= pop;
            rr_q        <= rr_d;
        end
    end

`ifdef SCHED_STATS_EN
    logic [15:0] conflict_count_q;
    logic [15:0] conflict_count_d;

    always_comb begin
        conflict_count_d = conflict_count_q;
        if (suppress && !issue_stall && conflict_count_q != 16'hFFFF) begin
            conflict_count_d = conflict_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_count_q <= '0;
        end else begin
            conflict_count_q <= conflict_count_d;
        end
    end

    assign conflict_count = conflict_count_q;
`endif

    assign port1_req_ready = in_ready[0];
    assign port2_req_ready = in_ready[1];
    assign port3_req_ready = in_ready[2];

    assign issue1_valid   = iss_valid_q[0];
    assign issue1_addr    = iss_q[0].addr;
    assign issue1_datain  = iss_q[0].datain;
    assign issue1_wen     = iss_q[0].wen;
    assign issue1_req_tag = iss_q[0].tag;
    assign issue1_id      = 2'd1;

    assign issue2_valid   = iss_valid_q[1];
    assign issue2_addr    = iss_q[1].addr;
    assign issue2_datain  = iss_q[1].datain;
    assign issue2_wen     = iss_q[1].wen;
    assign issue2_req_tag = iss_q[1].tag;
    assign issue2_id      = 2'd2;

    assign issue3_valid   = iss_valid_q[2];
    assign issue3_addr    = iss_q[2].addr;
    assign issue3_datain  = iss_q[2].datain;
    assign issue3_wen     = iss_q[2].wen;
    assign issue3_req_tag = iss_q[2].tag;
    assign issue3_id      = 2'd3;

endmodule

// File: tb/tb_port_request_scheduler.sv
// Scoreboard bench for port_request_scheduler: directed requests push expected lane/cycle
// entries; a negedge monitor pops and compares every valid issue lane.
module tb_port_request_scheduler;

    typedef struct {
        int          cyc;
        logic [9:0]  addr;
        logic [15:0] data;
        logic        wen;
        logic [1:0]  tag;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int k;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [2:0]  pv;
    logic [2:0]  pw;
    logic [9:0]  pa [3];
    logic [15:0] pd [3];
    logic [1:0]  pt [3];
    logic [2:0]  rdy;
    logic [2:0]  iv;
    logic [2:0]  iw;
    logic [9:0]  ia [3];
    logic [15:0] idat [3];
    logic [1:0]  itg [3];
    logic [1:0]  iid [3];
`ifdef SCHED_STATS_EN
    logic [15:0] ccount;
`endif

    port_request_scheduler #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .port1_req_valid(pv[0]), .port1_req_ready(rdy[0]), .port1_addr(pa[0]),
        .port1_datain(pd[0]), .port1_wen(pw[0]), .port1_req_tag_in(pt[0]),
        .port2_req_valid(pv[1]), .port2_req_ready(rdy[1]), .port2_addr(pa[1]),
        .port2_datain(pd[1]), .port2_wen(pw[1]), .port2_req_tag_in(pt[1]),
        .port3_req_valid(pv[2]), .port3_req_ready(rdy[2]), .port3_addr(pa[2]),
        .port3_datain(pd[2]), .port3_wen(pw[2]), .port3_req_tag_in(pt[2]),
        .issue_stall(stall),
        .issue1_valid(iv[0]), .issue1_addr(ia[0]), .issue1_datain(idat[0]),
        .issue1_wen(iw[0]), .issue1_req_tag(itg[0]), .issue1_id(iid[0]),
        .issue2_valid(iv[1]), .issue2_addr(ia[1]), .issue2_datain(idat[1]),
        .issue2_wen(iw[1]), .issue2_req_tag(itg[1]), .issue2_id(iid[1]),
        .issue3_valid(iv[2]), .issue3_addr(ia[2]), .issue3_datain(idat[2]),
        .issue3_wen(iw[2]), .issue3_req_tag(itg[2]),
`ifdef SCHED_STATS_EN
        .conflict_count(ccount),
`endif
        .issue3_id(iid[2])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [9:0] a, input logic [15:0] d,
                           input logic w, input logic [1:0] t);
        pv[p] = 1'b1;
        pa[p] = a;
        pd[p] = d;
        pw[p] = w;
        pt[p] = t;
    endtask

    task automatic clr_req();
        pv = '0;
    endtask

    task automatic exp_push(input int lane, input int c, input logic [9:0] a,
                            input logic [15:0] d, input logic w, input logic [1:0] t);
        exp_t e;
        e.cyc = c; e.addr = a; e.data = d; e.wen = w; e.tag = t;
        case (lane)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic mon_lane(input int lane);
        exp_t e;
        int   got;
        got = 0;
        if (iv[lane]) begin
            case (lane)
                0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1; end
                1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1; end
                default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1; end
            endcase
            nvec++;
            if (got == 0) begin
                nerr++;
                $display("FAIL lane%0d unexpected issue at cycle %0d: addr=%h data=%h",
                         lane + 1, cyc, ia[lane], idat[lane]);
            end else if (e.cyc != cyc || e.addr !== ia[lane] || e.data !== idat[lane] ||
                         e.wen !== iw[lane] || e.tag !== itg[lane]) begin
                nerr++;
                $display("FAIL lane%0d issue: got cyc=%0d addr=%h data=%h wen=%b tag=%h, want cyc=%0d addr=%h data=%h wen=%b tag=%h",
                         lane + 1, cyc, ia[lane], idat[lane], iw[lane], itg[lane],
                         e.cyc, e.addr, e.data, e.wen, e.tag);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon_lane(0);
            mon_lane(1);
            mon_lane(2);
            for (int i = 0; i < 3; i++) begin
                for (int j = i + 1; j < 3; j++) begin
                    if (iv[i] && iv[j]) begin
                        nvec++;
                        if (ia[i] == ia[j] && (iw[i] || iw[j])) begin
                            nerr++;
                            $display("FAIL bundle conflict lanes %0d/%0d addr=%h", i + 1, j + 1, ia[i]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; pv = '0; pw = '0;
        for (int i = 0; i < 3; i++) begin
            pa[i] = '0; pd[i] = '0; pt[i] = '0;
        end
        #1;
        chk("reset ready", 32'(rdy), 32'h7);
        chk("reset valid", 32'(iv), 32'h0);
        chk("reset lane1 addr", 32'(ia[0]), 32'h0);
        chk("reset lane2 data", 32'(idat[1]), 32'h0);
        chk("lane1 id", 32'(iid[0]), 32'h1);
        chk("lane2 id", 32'(iid[1]), 32'h2);
        chk("lane3 id", 32'(iid[2]), 32'h3);
`ifdef SCHED_STATS_EN
        chk("reset conflict_count", 32'(ccount), 32'h0);
`endif
        tick(); tick();
        rst = 1'b0;
        tick();

        // Three reads to distinct addresses issue together.
        k = cyc;
        set_req(0, 10'h010, 16'h1111, 1'b0, 2'd1);
        set_req(1, 10'h020, 16'h2222, 1'b0, 2'd2);
        set_req(2, 10'h030, 16'h3333, 1'b0, 2'd3);
        exp_push(0, k + 2, 10'h010, 16'h1111, 1'b0, 2'd1);
        exp_push(1, k + 2, 10'h020, 16'h2222, 1'b0, 2'd2);
        exp_push(2, k + 2, 10'h030, 16'h3333, 1'b0, 2'd3);
        tick(); clr_req();
        repeat (4) tick();

        // Write/write conflict at pointer P1: port 1 first, port 3 next cycle.
        k = cyc;
        set_req(0, 10'h055, 16'hAAAA, 1'b1, 2'd0);
        set_req(2, 10'h055, 16'hBBBB, 1'b1, 2'd3);
        exp_push(0, k + 2, 10'h055, 16'hAAAA, 1'b1, 2'd0);
        exp_push(2, k + 3, 10'h055, 16'hBBBB, 1'b1, 2'd3);
        tick(); clr_req();
        repeat (4) tick();
`ifdef SCHED_STATS_EN
        chk("conflict_count after ww", 32'(ccount), 32'h1);
`endif

        // Pointer P2: port 2 read beats port 1 write; port 3 read rides along.
        k = cyc;
        set_req(1, 10'h100, 16'h0000, 1'b0, 2'd1);
        set_req(0, 10'h100, 16'hC0DE, 1'b1, 2'd2);
        set_req(2, 10'h200, 16'h0303, 1'b0, 2'd0);
        exp_push(1, k + 2, 10'h100, 16'h0000, 1'b0, 2'd1);
        exp_push(2, k + 2, 10'h200, 16'h0303, 1'b0, 2'd0);
        exp_push(0, k + 3, 10'h100, 16'hC0DE, 1'b1, 2'd2);
        tick(); clr_req();
        repeat (4) tick();

        // Pointer P3: port 3 wins over port 1, wrapping 3->1.
        k = cyc;
        set_req(0, 10'h0AB, 16'h0A0A, 1'b1, 2'd1);
        set_req(2, 10'h0AB, 16'h0B0B, 1'b1, 2'd2);
        exp_push(2, k + 2, 10'h0AB, 16'h0B0B, 1'b1, 2'd2);
        exp_push(0, k + 3, 10'h0AB, 16'h0A0A, 1'b1, 2'd1);
        tick(); clr_req();
        repeat (4) tick();

        // Two reads of one address do not conflict.
        k = cyc;
        set_req(0, 10'h077, 16'h7001, 1'b0, 2'd0);
        set_req(1, 10'h077, 16'h7002, 1'b0, 2'd1);
        exp_push(0, k + 2, 10'h077, 16'h7001, 1'b0, 2'd0);
        exp_push(1, k + 2, 10'h077, 16'h7002, 1'b0, 2'd1);
        tick(); clr_req();
        repeat (4) tick();
`ifdef SCHED_STATS_EN
        chk("conflict_count after 3 conflicts", 32'(ccount), 32'h3);
`endif

        // Fill port 2 under stall, then drain in order.
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(1, 10'h140 + 10'(i), 16'h5000 + 16'(i), 1'(i), 2'(i));
            tick();
            chk($sformatf("fill ready after accept %0d", i + 1), 32'(rdy[1]), (i < 3) ? 32'h1 : 32'h0);
        end
        tick();
        chk("full ready held", 32'(rdy[1]), 32'h0);
        tick();
        k = cyc;
        stall = 1'b0;
        clr_req();
        for (int i = 0; i < 4; i++) begin
            exp_push(1, k + 1 + i, 10'h140 + 10'(i), 16'h5000 + 16'(i), 1'(i), 2'(i));
        end
        tick();
        chk("ready after first pop", 32'(rdy[1]), 32'h1);
        repeat (6) tick();

        // Queue three per port, issue one, then reset with two left in each FIFO.
        k = cyc;
        stall = 1'b1;
        for (int p = 0; p < 3; p++) set_req(p, 10'h300 + 10'(p), 16'hA000 + 16'(p), 1'b0, 2'(p));
        tick();
        for (int p = 0; p < 3; p++) set_req(p, 10'h310 + 10'(p), 16'hB000 + 16'(p), 1'b0, 2'(p));
        tick();
        for (int p = 0; p < 3; p++) set_req(p, 10'h320 + 10'(p), 16'hC000 + 16'(p), 1'b1, 2'(p));
        tick();
        clr_req();
        stall = 1'b0;
        for (int p = 0; p < 3; p++) exp_push(p, k + 4, 10'h300 + 10'(p), 16'hA000 + 16'(p), 1'b0, 2'(p));
        tick();
        #5;
        rst = 1'b1;
        #1;
        chk("async reset valid", 32'(iv), 32'h0);
        chk("async reset ready", 32'(rdy), 32'h7);
        chk("async reset lane3 addr", 32'(ia[2]), 32'h0);
        chk("async reset lane1 data", 32'(idat[0]), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("ready after reset release", 32'(rdy), 32'h7);
`ifdef SCHED_STATS_EN
        chk("conflict_count after reset", 32'(ccount), 32'h0);
`endif
        repeat (5) tick();

        // Fresh request after reset uses the cleared pointers.
        k = cyc;
        set_req(0, 10'h3FF, 16'hFACE, 1'b1, 2'd3);
        exp_push(0, k + 2, 10'h3FF, 16'hFACE, 1'b1, 2'd3);
        tick(); clr_req();
        repeat (5) tick();

        chk("lane1 pending expectations", 32'(q0.size()), 32'h0);
        chk("lane2 pending expectations", 32'(q1.size()), 32'h0);
        chk("lane3 pending expectations", 32'(q2.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
